// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter
// Purpose  : Shares one AXI read channel (AR/R) between the instruction-fetch
//            unit (I) and the load unit (D). One burst is in flight at a time.
//            Arbitration is round-robin. R beats are forwarded combinationally
//            to the requester that owns the burst.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            i_req_*, d_req_*    - burst request handshake (valid/ready/addr/len)
//            i_r*, d_r*          - forwarded read beats (valid/data/last)
//            m_axi_ar*           - AXI read-address channel (manager side)
//            m_axi_r*            - AXI read-data channel (manager side)
//            busy                - high whenever a burst is being serviced
//            proto_err           - sticky flag for R-channel protocol violations
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [7:0]            i_req_len,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rlast,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [7:0]            d_req_len,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rlast,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  busy,
    output logic                  proto_err
);

    // Owner encoding doubles as the AXI ID LSB.
    localparam logic C_OWNER_I = 1'b0;
    localparam logic C_OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic                  owner_q,      owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [7:0]            len_q,        len_d;
    logic [7:0]            beat_cnt_q,   beat_cnt_d;
    logic                  arvalid_q,    arvalid_d;
    logic                  rready_q,     rready_d;
    logic                  busy_q,       busy_d;
    logic                  proto_err_q,  proto_err_d;

    logic w_idle;
    logic w_pick_d;
    logic w_beat;
    logic w_beat_err;

    assign w_idle = (state_q == ST_IDLE);

    // D wins when it is the only requester, or on a tie when I was served last.
    assign w_pick_d = d_req_valid && (!i_req_valid || (last_grant_q == C_OWNER_I));

    // rready_q is high exactly in DATA, so this is an accepted beat.
    assign w_beat = rready_q && m_axi_rvalid;

    // The beat counter holds the index of the current beat, so a well-formed
    // burst shows rlast exactly when the index reaches the programmed len.
    assign w_beat_err = (m_axi_rid != m_axi_arid)
                     || (m_axi_rresp != 2'b00)
                     || (m_axi_rlast && (beat_cnt_q != len_q))
                     || (!m_axi_rlast && (beat_cnt_q == len_q));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        busy_d       = busy_q;
        proto_err_d  = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid || d_req_valid) begin
                    owner_d   = w_pick_d ? C_OWNER_D : C_OWNER_I;
                    addr_d    = w_pick_d ? d_req_addr : i_req_addr;
                    len_d     = w_pick_d ? d_req_len  : i_req_len;
                    state_d   = ST_ADDR;
                    arvalid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) begin
                    state_d   = ST_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (w_beat_err) begin
                        proto_err_d = 1'b1;
                    end
                    // Only rlast closes a burst, even a malformed one.
                    if (m_axi_rlast) begin
                        state_d      = ST_IDLE;
                        rready_d     = 1'b0;
                        busy_d       = 1'b0;
                        last_grant_d = owner_q;
                        beat_cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= C_OWNER_I;
            last_grant_q <= C_OWNER_D;
            addr_q       <= '0;
            len_q        <= 8'd0;
            beat_cnt_q   <= 8'd0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            busy_q       <= busy_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Request handshake: only the winner sees ready, and only while idle.
    assign i_req_ready = w_idle && i_req_valid && !w_pick_d;
    assign d_req_ready = w_idle && w_pick_d;

    // AR channel driven from registered burst fields.
    assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, owner_q};
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = (owner_q == C_OWNER_D) ? 2'b01 : 2'b10;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = (owner_q == C_OWNER_D) ? 3'b000 : 3'b100;
    assign m_axi_arvalid = arvalid_q;

    assign m_axi_rready = rready_q;

    // R beats steered to the owner; the other requester never sees a beat.
    assign i_rvalid = w_beat && (owner_q == C_OWNER_I);
    assign d_rvalid = w_beat && (owner_q == C_OWNER_D);
    assign i_rdata  = m_axi_rdata;
    assign d_rdata  = m_axi_rdata;
    assign i_rlast  = i_rvalid && m_axi_rlast;
    assign d_rlast  = d_rvalid && m_axi_rlast;

    assign busy      = busy_q;
    assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_arbiter
// Purpose  : Directed scoreboard bench for axi_read_arbiter. Stimulus tasks
//            push expected AR transactions and R beats into queues; a monitor
//            on the falling edge pops and compares whenever the DUT shows an
//            AR handshake or a forwarded beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;

    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_req_valid, i_req_ready;
    logic [AW-1:0]  i_req_addr;
    logic [7:0]     i_req_len;
    logic           i_rvalid, i_rlast;
    logic [DW-1:0]  i_rdata;
    logic           d_req_valid, d_req_ready;
    logic [AW-1:0]  d_req_addr;
    logic [7:0]     d_req_len;
    logic           d_rvalid, d_rlast;
    logic [DW-1:0]  d_rdata;
    logic [IDW-1:0] m_axi_arid;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic [2:0]     m_axi_arsize;
    logic [1:0]     m_axi_arburst;
    logic           m_axi_arlock;
    logic [3:0]     m_axi_arcache;
    logic [2:0]     m_axi_arprot;
    logic           m_axi_arvalid, m_axi_arready;
    logic [IDW-1:0] m_axi_rid;
    logic [DW-1:0]  m_axi_rdata;
    logic [1:0]     m_axi_rresp;
    logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic           busy, proto_err;

    always #5 clk = ~clk;

    axi_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_addr(d_req_addr), .d_req_len(d_req_len),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .busy(busy), .proto_err(proto_err)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [1:0]     burst;
        logic [2:0]     prot;
    } ar_t;

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    ar_t   ar_q[$];
    beat_t beat_q[$];
    ar_t   mon_ar;
    beat_t mon_b;
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_q.size() == 0) begin
                    check("ar_unexpected", 64'(1), 64'(0));
                end else begin
                    mon_ar = ar_q.pop_front();
                    check("arid",    64'(m_axi_arid),    64'(mon_ar.id));
                    check("araddr",  64'(m_axi_araddr),  64'(mon_ar.addr));
                    check("arlen",   64'(m_axi_arlen),   64'(mon_ar.len));
                    check("arburst", 64'(m_axi_arburst), 64'(mon_ar.burst));
                    check("arprot",  64'(m_axi_arprot),  64'(mon_ar.prot));
                    check("arsize",  64'(m_axi_arsize),  64'(3'b011));
                    check("arcache", 64'(m_axi_arcache), 64'(4'b0011));
                    check("arlock",  64'(m_axi_arlock),  64'(0));
                end
            end
            if (i_rvalid && d_rvalid) begin
                check("r_both_owners", 64'(1), 64'(0));
            end else if (i_rvalid || d_rvalid) begin
                if (beat_q.size() == 0) begin
                    check("r_unexpected", 64'(1), 64'(0));
                end else begin
                    mon_b = beat_q.pop_front();
                    check("r_owner", 64'(d_rvalid), 64'(mon_b.owner));
                    check("r_data",  d_rvalid ? d_rdata : i_rdata, mon_b.data);
                    check("r_last",  64'(d_rvalid ? d_rlast : i_rlast), 64'(mon_b.last));
                end
            end
            if (busy) begin
                check("req_ready_while_busy", 64'({i_req_ready, d_req_ready}), 64'(0));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_ar(input logic side, input logic [AW-1:0] addr, input logic [7:0] len);
        ar_t e;
        e.id    = IDW'(side);
        e.addr  = addr;
        e.len   = len;
        e.burst = side ? 2'b01 : 2'b10;
        e.prot  = side ? 3'b000 : 3'b100;
        ar_q.push_back(e);
    endtask

    // Waits (bounded) for the requester's ready, then steps past the accepting edge.
    task automatic wait_ready(input logic side);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = side ? d_req_ready : i_req_ready;
            if (!got) tick();
        end
        check(side ? "d_req_ready_seen" : "i_req_ready_seen", 64'(got), 64'(1));
        tick();
    endtask

    task automatic request(input logic side, input logic [AW-1:0] addr, input logic [7:0] len);
        push_ar(side, addr, len);
        if (side) begin
            d_req_valid = 1'b1; d_req_addr = addr; d_req_len = len;
        end else begin
            i_req_valid = 1'b1; i_req_addr = addr; i_req_len = len;
        end
        wait_ready(side);
        if (side) d_req_valid = 1'b0;
        else      i_req_valid = 1'b0;
    endtask

    // Holds arready low for 'delay' cycles checking AR stability, then accepts.
    task automatic ar_accept(input int delay, input logic [AW-1:0] addr, input logic [7:0] len);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check("arvalid_held", 64'(m_axi_arvalid), 64'(1));
            check("araddr_held",  64'(m_axi_araddr),  64'(addr));
            check("arlen_held",   64'(m_axi_arlen),   64'(len));
            check("ireq_ready_in_addr", 64'(i_req_ready), 64'(0));
            tick();
        end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
    endtask

    task automatic beats(input logic side, input int n, input int last_at, input int bad_resp_at,
                         input logic [DW-1:0] base);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = base + DW'(b);
            m_axi_rlast  = (b == last_at);
            m_axi_rid    = IDW'(side);
            m_axi_rresp  = (b == bad_resp_at) ? 2'b10 : 2'b00;
            e.owner = side;
            e.data  = base + DW'(b);
            e.last  = (b == last_at);
            beat_q.push_back(e);
            tick();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        i_req_valid = 1'b0; i_req_addr = '0; i_req_len = 8'd0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_len = 8'd0;
        m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_arvalid",   64'(m_axi_arvalid), 64'(0));
        check("rst_rready",    64'(m_axi_rready),  64'(0));
        check("rst_req_ready", 64'({i_req_ready, d_req_ready}), 64'(0));
        check("rst_rvalid",    64'({i_rvalid, d_rvalid}), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_proto_err", 64'(proto_err), 64'(0));
        tick();
        reset = 1'b0;

        // 1: lone I burst, 8 beats, immediate arready
        request(1'b0, 64'h1000, 8'd7);
        ar_accept(0, 64'h1000, 8'd7);
        beats(1'b0, 8, 7, -1, 64'hA100_0000_0000_0000);
        @(negedge clk);
        check("t1_busy_after", 64'(busy), 64'(0));
        check("t1_proto_err",  64'(proto_err), 64'(0));
        tick();

        // 2: tie after reset -> I first, then D
        do_reset();
        push_ar(1'b0, 64'h2000, 8'd1);
        push_ar(1'b1, 64'h3000, 8'd0);
        i_req_valid = 1'b1; i_req_addr = 64'h2000; i_req_len = 8'd1;
        d_req_valid = 1'b1; d_req_addr = 64'h3000; d_req_len = 8'd0;
        @(negedge clk);
        check("t2_grant_i",  64'(i_req_ready), 64'(1));
        check("t2_stall_d",  64'(d_req_ready), 64'(0));
        tick();
        i_req_valid = 1'b0;
        ar_accept(0, 64'h2000, 8'd1);
        beats(1'b0, 2, 1, -1, 64'hA200_0000_0000_0000);
        wait_ready(1'b1);
        d_req_valid = 1'b0;
        ar_accept(0, 64'h3000, 8'd0);
        beats(1'b1, 1, 0, -1, 64'hD300_0000_0000_0000);

        // 3: arready held low 5 cycles while I also requests
        request(1'b1, 64'h4000, 8'd1);
        i_req_valid = 1'b1; i_req_addr = 64'h5000; i_req_len = 8'd0;
        ar_accept(5, 64'h4000, 8'd1);
        i_req_valid = 1'b0;
        beats(1'b1, 2, 1, -1, 64'hD400_0000_0000_0000);

        // 4: D len=3 but rlast on second beat
        @(negedge clk);
        check("t4_err_before", 64'(proto_err), 64'(0));
        tick();
        request(1'b1, 64'h6000, 8'd3);
        ar_accept(0, 64'h6000, 8'd3);
        beats(1'b1, 2, 1, -1, 64'hD600_0000_0000_0000);
        @(negedge clk);
        check("t4_busy_after", 64'(busy), 64'(0));
        check("t4_err_set",    64'(proto_err), 64'(1));
        tick();
        tick();
        @(negedge clk);
        check("t4_err_sticky", 64'(proto_err), 64'(1));
        tick();
        request(1'b0, 64'h7000, 8'd1);
        ar_accept(0, 64'h7000, 8'd1);
        beats(1'b0, 2, 1, -1, 64'hA700_0000_0000_0000);
        @(negedge clk);
        check("t4_next_busy",  64'(busy), 64'(0));
        check("t4_err_still",  64'(proto_err), 64'(1));
        tick();

        // 5: SLVERR response on a beat
        do_reset();
        @(negedge clk);
        check("t5_err_cleared", 64'(proto_err), 64'(0));
        tick();
        request(1'b0, 64'h8000, 8'd2);
        ar_accept(0, 64'h8000, 8'd2);
        beats(1'b0, 3, 2, 1, 64'hA800_0000_0000_0000);
        @(negedge clk);
        check("t5_err_set", 64'(proto_err), 64'(1));
        tick();

        // 6: reset during beat 4 of 8; stale beat must stall
        request(1'b0, 64'h9000, 8'd7);
        ar_accept(0, 64'h9000, 8'd7);
        beats(1'b0, 3, 7, -1, 64'hA900_0000_0000_0000);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 64'hA900_0000_0000_0003;
        m_axi_rid    = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_busy",      64'(busy),          64'(0));
        check("t6_rready",    64'(m_axi_rready),  64'(0));
        check("t6_arvalid",   64'(m_axi_arvalid), 64'(0));
        check("t6_i_rvalid",  64'(i_rvalid),      64'(0));
        check("t6_proto_err", 64'(proto_err),     64'(0));
        tick();
        m_axi_rvalid = 1'b0;

        // recovery burst after mid-burst reset
        request(1'b1, 64'hA000, 8'd0);
        ar_accept(0, 64'hA000, 8'd0);
        beats(1'b1, 1, 0, -1, 64'hDA00_0000_0000_0000);
        @(negedge clk);
        check("end_busy",      64'(busy), 64'(0));
        check("end_ar_left",   64'(ar_q.size()),   64'(0));
        check("end_beat_left", 64'(beat_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
